// File: rtl/lcd_spi_byte_tx.sv
// ============================================================================
// lcd_spi_byte_tx : one-byte-at-a-time SPI mode-3 serializer for the LCD bus
// Optional build macro: LCD_SPI_BURST_EN (back-to-back bytes inside one CS frame)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_spi_byte_tx #(
   parameter int HALF_PERIOD = 1,
   parameter int CS_GAP      = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_dc,
   output logic       busy,
   output logic       done,
   output logic       SCL,
   output logic       MOSI,
   output logic       DC,
   output logic       CS
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   logic [1:0]  state;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [6:0]  shreg;

   logic cnt_last;
   logic gap_last;
   logic last_phase;
   logic accept;

   assign cnt_last   = (cnt == HP_LAST);
   assign gap_last   = (cnt == GAP_LAST);
   assign last_phase = (state == ST_SHIFT) && SCL && (bit_cnt == 3'd0) && cnt_last;

`ifdef LCD_SPI_BURST_EN
   assign in_ready = (state == ST_IDLE) || last_phase;
`else
   assign in_ready = (state == ST_IDLE);
`endif

   assign accept = in_valid && in_ready;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         cnt     <= 16'd0;
         bit_cnt <= 3'd0;
         shreg   <= 7'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         SCL     <= 1'b1;
         MOSI    <= 1'b1;
         DC      <= 1'b1;
         CS      <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_SETUP;
                  busy  <= 1'b1;
                  CS    <= 1'b0;
                  SCL   <= 1'b1;
                  DC    <= in_dc;
                  MOSI  <= in_data[7];
                  shreg <= in_data[6:0];
                  cnt   <= 16'd0;
               end
            end
            ST_SETUP: begin
               if (cnt_last) begin
                  state   <= ST_SHIFT;
                  SCL     <= 1'b0;
                  cnt     <= 16'd0;
                  bit_cnt <= 3'd7;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_SHIFT: begin
               if (!cnt_last) begin
                  cnt <= cnt + 16'd1;
               end else begin
                  cnt <= 16'd0;
                  if (!SCL) begin
                     SCL <= 1'b1;
                  end else if (bit_cnt != 3'd0) begin
                     // MOSI only moves as SCL falls, so it is stable across the rising edge
                     SCL     <= 1'b0;
                     bit_cnt <= bit_cnt - 3'd1;
                     MOSI    <= shreg[6];
                     shreg   <= {shreg[5:0], 1'b0};
                  end else begin
                     done <= 1'b1;
                     if (accept) begin
                        // burst: next byte starts straight in its first low phase, CS kept low
                        SCL     <= 1'b0;
                        bit_cnt <= 3'd7;
                        DC      <= in_dc;
                        MOSI    <= in_data[7];
                        shreg   <= in_data[6:0];
                     end else begin
                        state <= ST_GAP;
                        CS    <= 1'b1;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (gap_last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= 16'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_byte_tx.sv
// ============================================================================
// tb_lcd_spi_byte_tx : directed bench for lcd_spi_byte_tx (H=1 and H=3 instances)
// Burst expectations selected with LCD_SPI_BURST_EN. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_spi_byte_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic [7:0] data;
   logic       dc;
   logic       sel;

   logic a_ready, a_busy, a_done, a_scl, a_mosi, a_dc, a_cs;
   logic b_ready, b_busy, b_done, b_scl, b_mosi, b_dc, b_cs;
   logic ready_m, busy_m, done_m, scl_m, mosi_m, dc_m, cs_m;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lcd_spi_byte_tx #(.HALF_PERIOD(1), .CS_GAP(2)) dut_a (
      .CLK(clk), .RST_N(rst_n), .in_valid(valid && !sel), .in_ready(a_ready),
      .in_data(data), .in_dc(dc), .busy(a_busy), .done(a_done),
      .SCL(a_scl), .MOSI(a_mosi), .DC(a_dc), .CS(a_cs)
   );

   lcd_spi_byte_tx #(.HALF_PERIOD(3), .CS_GAP(2)) dut_b (
      .CLK(clk), .RST_N(rst_n), .in_valid(valid && sel), .in_ready(b_ready),
      .in_data(data), .in_dc(dc), .busy(b_busy), .done(b_done),
      .SCL(b_scl), .MOSI(b_mosi), .DC(b_dc), .CS(b_cs)
   );

   assign ready_m = sel ? b_ready : a_ready;
   assign busy_m  = sel ? b_busy  : a_busy;
   assign done_m  = sel ? b_done  : a_done;
   assign scl_m   = sel ? b_scl   : a_scl;
   assign mosi_m  = sel ? b_mosi  : a_mosi;
   assign dc_m    = sel ? b_dc    : a_dc;
   assign cs_m    = sel ? b_cs    : a_cs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the selected DUT idle; returns at the negedge where in_ready reappears.
   task automatic send_byte(input logic [7:0] d, input logic c, input int h, input int gap,
                            input bit keep, input bit chg);
      logic [7:0] bits = 8'd0;
      int rises = 0, first_rise = 0, cs_cnt = 0, cs_first = 0, cs_last = 0;
      int dc_bad = 0, done_n = 0, done_cyc = 0, ready_cyc = 0;
      logic scl_prev = 1'b1;
      int lim = 17 * h + gap + 4;
      check("ready_before_accept", 32'(ready_m), 32'd1);
      data  = d;
      dc    = c;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 1; k <= lim; k++) begin
         if (k == 1) check("busy_after_accept", 32'(busy_m), 32'd1);
         if (chg && k == 2) data = 8'hFF;
         if (!cs_m) begin
            cs_cnt++;
            if (cs_first == 0) cs_first = k;
            cs_last = k;
            if (dc_m !== c) dc_bad++;
         end
         if (scl_m && !scl_prev) begin
            bits = {bits[6:0], mosi_m};
            rises++;
            if (first_rise == 0) first_rise = k;
         end
         scl_prev = scl_m;
         if (done_m) begin
            done_n++;
            done_cyc = k;
         end
         if (ready_m) begin
            ready_cyc = k;
            break;
         end
         @(negedge clk);
      end
      if (!keep) valid = 1'b0;
      check("mosi_bits", 32'(bits), 32'(d));
      check("scl_rises", 32'(rises), 32'd8);
      check("first_rise_cycle", 32'(first_rise), 32'(2 * h + 1));
      check("cs_first_low", 32'(cs_first), 32'd1);
      check("cs_last_low", 32'(cs_last), 32'(17 * h));
      check("cs_low_count", 32'(cs_cnt), 32'(17 * h));
      check("dc_during_byte", 32'(dc_bad), 32'd0);
      check("done_count", 32'(done_n), 32'd1);
      check("done_cycle", 32'(done_cyc), 32'(17 * h + 1));
      check("ready_cycle", 32'(ready_cyc), 32'(17 * h + gap + 1));
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 8'h00;
      dc    = 1'b0;
      sel   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pins", {26'd0, a_scl, a_cs, a_dc, a_mosi, a_busy, a_done}, 32'b111100);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(a_ready), 32'd1);

`ifdef LCD_SPI_BURST_EN
      begin
         logic [7:0] bytes [4];
         logic       dcs   [4];
         logic [31:0] bits32 = 32'd0, dcbits = 32'd0;
         int idx = 0, cs_low = 0, cs_falls = 0, dn = 0, rises = 0;
         bit pending = 1'b0;
         logic cs_prev = 1'b1, scl_prev = 1'b1;
         bytes[0] = 8'hB1; bytes[1] = 8'h05; bytes[2] = 8'h3C; bytes[3] = 8'h3C;
         dcs[0] = 1'b0; dcs[1] = 1'b1; dcs[2] = 1'b0; dcs[3] = 1'b1;
         data  = bytes[0];
         dc    = dcs[0];
         valid = 1'b1;
         for (int k = 0; k < 200; k++) begin
            if (pending) begin
               idx++;
               if (idx < 4) begin
                  data = bytes[idx];
                  dc   = dcs[idx];
               end else begin
                  valid = 1'b0;
               end
               pending = 1'b0;
            end
            if (a_ready && valid) pending = 1'b1;
            if (!a_cs) cs_low++;
            if (cs_prev && !a_cs) cs_falls++;
            cs_prev = a_cs;
            if (a_scl && !scl_prev) begin
               bits32 = {bits32[30:0], a_mosi};
               dcbits = {dcbits[30:0], a_dc};
               rises++;
            end
            scl_prev = a_scl;
            if (a_done) dn++;
            @(negedge clk);
         end
         check("burst_bits", bits32, 32'hB1053C3C);
         check("burst_dc", dcbits, 32'h00FF00FF);
         check("burst_rises", 32'(rises), 32'd32);
         check("burst_cs_low", 32'(cs_low), 32'd65);
         check("burst_cs_frames", 32'(cs_falls), 32'd1);
         check("burst_done", 32'(dn), 32'd4);
         check("burst_idle", 32'(a_ready), 32'd1);
      end
`else
      send_byte(8'hB1, 1'b0, 1, 2, 1'b0, 1'b0);
      @(negedge clk);
      sel = 1'b1;
      send_byte(8'h3C, 1'b1, 3, 2, 1'b0, 1'b0);
      @(negedge clk);
      sel = 1'b0;
      @(negedge clk);
      send_byte(8'hB1, 1'b0, 1, 2, 1'b1, 1'b0);
      send_byte(8'h05, 1'b1, 1, 2, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b0, 1, 2, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b1, 1, 2, 1'b0, 1'b0);
      send_byte(8'hB1, 1'b0, 1, 2, 1'b0, 1'b1);
      @(negedge clk);
`endif

      // asynchronous reset in the middle of a byte
      data  = 8'h00;
      dc    = 1'b0;
      valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (8) @(negedge clk);
      check("midbyte_pre_reset", {28'd0, a_cs, a_dc, a_mosi, a_busy}, 32'b0001);
      rst_n = 1'b0;
      #1;
      check("midbyte_async_reset", {26'd0, a_scl, a_cs, a_dc, a_mosi, a_busy, a_done}, 32'b111100);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_abort", 32'(a_ready), 32'd1);
`ifdef LCD_SPI_BURST_EN
      check("abort_cs_idle", 32'(a_cs), 32'd1);
`else
      send_byte(8'hA5, 1'b1, 1, 2, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
